// File: rtl/pixel_fetch.sv
// Avalon-MM read master that streams a contiguous 16-bit image into the sobel stage through a FWFT FIFO.
// Optional build macro SWAP_BYTES_EN byte-swaps each returned word (big-endian image files).
module pixel_fetch #(
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 18
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ready,
    input  logic             cont,
    output logic             done,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_pixels,
    output logic [31:0]      address,
    output logic             read_n,
    output logic             chipselect,
    output logic [1:0]       byteenable,
    input  logic             waitrequest,
    input  logic             readdatavalid,
    input  logic [15:0]      readdata,
    output logic [15:0]      pix_data,
    output logic             pix_valid,
    input  logic             pix_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] num_r;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] returned;
    logic [OUT_W-1:0] outstanding;

    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic             accept;
    logic             push;
    logic             pop;
    logic             can_issue;
    logic [CNT_W-1:0] issued_nxt;
    logic [OUT_W-1:0] out_nxt;
    logic [OCC_W-1:0] occ_nxt;
    logic [15:0]      wr_data;

    assign byteenable = 2'b11;
    assign pix_valid  = (occ != '0);
    assign pix_data   = mem[rd_ptr];

`ifdef SWAP_BYTES_EN
    assign wr_data = {readdata[7:0], readdata[15:8]};
`else
    assign wr_data = readdata;
`endif

    // Returns arriving in IDLE are leftovers from a read cut short by reset.
    assign accept = (state == S_FETCH) && !read_n && !waitrequest;
    assign push   = readdatavalid && ((state == S_FETCH) || (state == S_DRAIN));
    assign pop    = pix_valid && pix_ready;

    assign issued_nxt = issued + CNT_W'(accept);
    assign out_nxt    = outstanding + OUT_W'(accept) - OUT_W'(push);
    assign occ_nxt    = occ + OCC_W'(push) - OCC_W'(pop);

    // Every issued read must already own a FIFO slot, so outstanding plus occupancy bounds issue.
    assign can_issue = (issued_nxt < num_r)
                    && ((int'(out_nxt) + int'(occ_nxt)) < FIFO_DEPTH)
                    && (int'(out_nxt) < MAX_OUTSTANDING);

    // NOTE: the storage array has no reset; only pointers and occupancy define its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            occ <= occ_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push && !pop) assert (occ != OCC_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            read_n      <= 1'b1;
            chipselect  <= 1'b0;
            done        <= 1'b0;
            address     <= '0;
            num_r       <= '0;
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
        end else begin
            issued      <= issued_nxt;
            outstanding <= out_nxt;
            if (push)   returned <= returned + CNT_W'(1);
            if (accept) address  <= address + 32'd2;

            // NOTE: later non-blocking assignments in this block override the defaults above.
            case (state)
                S_IDLE: begin
                    if (ready) begin
                        address     <= base_addr;
                        num_r       <= num_pixels;
                        issued      <= '0;
                        returned    <= '0;
                        outstanding <= '0;
                        if (num_pixels == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (read_n || !waitrequest) begin
                        if (issued_nxt == num_r) begin
                            read_n     <= 1'b1;
                            chipselect <= 1'b0;
                            state      <= S_DRAIN;
                        end else begin
                            read_n     <= !can_issue;
                            chipselect <= can_issue;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((returned == num_r) && (occ == '0)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (cont) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch: Avalon slave model with fixed read latency and a pixel scoreboard.
module tb_pixel_fetch;

    localparam int LAT = 2;

    logic        clk;
    logic        reset_n;
    logic        ready;
    logic        cont;
    logic        done;
    logic [31:0] base_addr;
    logic [17:0] num_pixels;
    logic [31:0] address;
    logic        read_n;
    logic        chipselect;
    logic [1:0]  byteenable;
    logic        waitrequest;
    logic        readdatavalid;
    logic [15:0] readdata;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    pixel_fetch dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ready        (ready),
        .cont         (cont),
        .done         (done),
        .base_addr    (base_addr),
        .num_pixels   (num_pixels),
        .address      (address),
        .read_n       (read_n),
        .chipselect   (chipselect),
        .byteenable   (byteenable),
        .waitrequest  (waitrequest),
        .readdatavalid(readdatavalid),
        .readdata     (readdata),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_4000) return 16'h12AB;
        return a[16:1] ^ 16'hC35A;
    endfunction

    function automatic logic [15:0] exp_pix(input logic [15:0] w);
`ifdef SWAP_BYTES_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

`ifdef SWAP_BYTES_EN
    localparam logic [15:0] EXP_SWAP = 16'hAB12;
`else
    localparam logic [15:0] EXP_SWAP = 16'h12AB;
`endif

    // Slave model and scoreboard state
    int          stall_req    = 0;
    int          stale_inject = 0;
    logic        p_v [LAT];
    logic [31:0] p_a [LAT];
    logic [15:0] exp_q [$];
    logic [31:0] exp_base;
    logic [31:0] last_addr;
    int          cur_n   = 0;
    int          n_reads = 0;
    int          n_pops  = 0;

    initial begin
        for (int i = 0; i < LAT; i++) begin
            p_v[i] = 1'b0;
            p_a[i] = '0;
        end
    end

    // Slave: decides waitrequest for the coming edge, returns data LAT edges after acceptance.
    always @(negedge clk) begin
        logic acc;
        #1;
        if (!read_n && stall_req > 0) begin
            waitrequest = 1'b1;
            stall_req--;
        end else begin
            waitrequest = 1'b0;
        end
        acc = reset_n && !read_n && !waitrequest;
        readdatavalid = p_v[LAT-1];
        readdata      = mem_word(p_a[LAT-1]);
        for (int i = LAT - 1; i > 0; i--) begin
            p_v[i] = p_v[i-1];
            p_a[i] = p_a[i-1];
        end
        p_v[0] = acc;
        p_a[0] = address;
        if (stale_inject > 0) begin
            readdatavalid = 1'b1;
            readdata      = 16'hDEAD;
            stale_inject--;
        end
    end

    // Monitor: checks every accepted read address and every popped pixel.
    always @(negedge clk) begin
        #3;
        if (reset_n) begin
            check("cs_vs_read_n", chipselect, !read_n);
            if (!read_n && !waitrequest) begin
                check("rd_addr", address, exp_base + 32'(2 * n_reads));
                check("rd_in_range", n_reads < cur_n, 1);
                last_addr = address;
                n_reads++;
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("pix_unexpected", pix_valid, 0);
                end else begin
                    check("pix_data", pix_data, exp_q.pop_front());
                end
                n_pops++;
            end
        end
    end

    task automatic start_run(input logic [31:0] b, input int n);
        @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(exp_pix(mem_word(b + 32'(2 * i))));
        exp_base   = b;
        cur_n      = n;
        n_reads    = 0;
        n_pops     = 0;
        last_addr  = 32'hDEAD_BEEF;
        base_addr  = b;
        num_pixels = 18'(n);
        ready      = 1'b1;
        @(negedge clk);
        ready      = 1'b0;
    endtask

    task automatic finish_run(input int n, input logic [31:0] exp_last, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #3;
            if (done) break;
        end
        check("done_seen", done, 1);
        check("reads", n_reads, n);
        check("pops", n_pops, n);
        check("last_addr", last_addr, exp_last);
        repeat (3) @(negedge clk);
        #3;
        check("done_held", done, 1);
        @(negedge clk);
        cont = 1'b1;
        @(negedge clk);
        cont = 1'b0;
        #3;
        check("done_clr", done, 0);
    endtask

    typedef struct {
        logic [31:0] base;
        int          n;
        int          stall;
        int          bound;
        logic [31:0] exp_last;
    } run_t;

    run_t runs [5];

    initial begin
        runs[0] = '{base: 32'h0000_1000, n: 4,  stall: 0, bound: 60,  exp_last: 32'h0000_1006};
        runs[1] = '{base: 32'h0000_1000, n: 3,  stall: 5, bound: 60,  exp_last: 32'h0000_1004};
        runs[2] = '{base: 32'hFFFF_FFFC, n: 4,  stall: 0, bound: 60,  exp_last: 32'h0000_0002};
        runs[3] = '{base: 32'h0000_2000, n: 20, stall: 0, bound: 200, exp_last: 32'h0000_2026};
        runs[4] = '{base: 32'h0000_3000, n: 0,  stall: 0, bound: 10,  exp_last: 32'hDEAD_BEEF};

        reset_n    = 1'b0;
        ready      = 1'b0;
        cont       = 1'b0;
        base_addr  = '0;
        num_pixels = '0;
        pix_ready  = 1'b1;
        exp_base   = '0;
        last_addr  = '0;

        repeat (2) @(negedge clk);
        #3;
        check("rst_read_n", read_n, 1);
        check("rst_cs", chipselect, 0);
        check("rst_done", done, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_address", address, 0);
        check("byteenable", byteenable, 2'b11);
        @(negedge clk);
        reset_n = 1'b1;

        for (int r = 0; r < 5; r++) begin
            stall_req = runs[r].stall;
            start_run(runs[r].base, runs[r].n);
            finish_run(runs[r].n, runs[r].exp_last, runs[r].bound);
        end

        // Stall: address and read_n must hold while waitrequest is high
        stall_req = 5;
        start_run(32'h0000_1000, 3);
        for (int i = 0; i < 10; i++) begin
            #3;
            if (!read_n) break;
            @(negedge clk);
        end
        check("stall_read_seen", read_n, 0);
        for (int i = 0; i < 5; i++) begin
            check("stall_addr", address, 32'h0000_1000);
            check("stall_read_n", read_n, 0);
            check("stall_wait", waitrequest, 1);
            check("stall_no_accept", n_reads, 0);
            @(negedge clk);
            #3;
        end
        finish_run(3, 32'h0000_1004, 60);

        // Zero length: done on the next cycle, no reads
        start_run(32'h0000_5000, 0);
        #3;
        check("zero_done_next", done, 1);
        check("zero_read_n", read_n, 1);
        finish_run(0, 32'hDEAD_BEEF, 5);

        // Backpressure: FIFO fills, issue stops at FIFO_DEPTH
        pix_ready = 1'b0;
        start_run(32'h0000_8000, 64);
        repeat (60) @(negedge clk);
        #3;
        check("bp_reads", n_reads, 16);
        check("bp_read_n", read_n, 1);
        check("bp_pix_valid", pix_valid, 1);
        check("bp_no_pops", n_pops, 0);
        pix_ready = 1'b1;
        finish_run(64, 32'h0000_807E, 600);

        // Reset mid-transfer with stale returns arriving in IDLE
        start_run(32'h0000_1000, 10);
        for (int i = 0; i < 50; i++) begin
            #3;
            if (n_reads >= 5) break;
            @(negedge clk);
        end
        check("rst_mid_reads", n_reads >= 5, 1);
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        cur_n = 0;
        @(negedge clk);
        reset_n      = 1'b1;
        stale_inject = 2;
        #3;
        check("rst_mid_read_n", read_n, 1);
        check("rst_mid_cs", chipselect, 0);
        check("rst_mid_address", address, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_pix_valid", pix_valid, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            check("idle_stale_dropped", pix_valid, 0);
        end
        start_run(32'h0000_1000, 3);
        finish_run(3, 32'h0000_1004, 60);

        // Byte order of the stored word
        pix_ready = 1'b0;
        start_run(32'h0000_4000, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #3;
            if (pix_valid) break;
        end
        check("swap_valid", pix_valid, 1);
        check("swap_pix", pix_data, EXP_SWAP);
        pix_ready = 1'b1;
        finish_run(1, 32'h0000_4000, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
